alu_cmd_seq: RTL and testbench
==============================

# alu_cmd_seq

UART-to-ALU command sequencer. It takes 2-byte commands from the `uart` receive strobe and decodes operand/destination register indices and the opcode. It fires one ALU execute, waits a fixed result latency, then returns the 16-bit result and overflow flag over the `uart` transmitter. It sits between the `uart` instance and the `alu` instance in `top`, replacing the free-running index counters with host-driven sequencing.

## Interface
Parameters:
- `RES_LAT`, 2: cycles from `alu_exec` pulse to valid `alu_res`/`alu_overflow` (1..15).
- `TIMEOUT`, 1_000_000: max cycles between byte0 and byte1 before the command is abandoned.
- `TO_W`, 24: width of the timeout counter; `TIMEOUT` < 2^`TO_W`.

Ports:
- `CLK` in 1: system clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte, valid while `rx_ready`.
- `rx_ready` in 1: single-cycle strobe, one new byte.
- `tx_data` out 8: byte to transmit.
- `tx_start` out 1: single-cycle transmit request.
- `tx_busy` in 1: transmitter busy.
- `alu_a` out 3, `alu_b` out 3, `alu_y` out 3: register indices.
- `alu_op` out 2: ALU opcode.
- `alu_exec` out 1: single-cycle execute strobe.
- `alu_res` in 16: ALU result.
- `alu_overflow` in 1: ALU overflow.
- `busy` out 1: high whenever state != IDLE.
- `dropped` out 1: sticky; a byte arrived while in EXEC/WAIT/TX states. Cleared only by reset.

## Operation
- Command format:
  - byte0 = {op[1:0], a[2:0], b[2:0]} (bits 7:6, 5:3, 2:0).
  - byte1 = {5'b0, y[2:0]}. Upper 5 bits are ignored.
- States:
  - IDLE: on `rx_ready`, latch byte0, go to HDR.
  - HDR: on `rx_ready`, latch y, go to EXEC. If the timeout counter reaches `TIMEOUT` first, go to IDLE. The counter clears on entry to HDR.
  - EXEC: assert `alu_exec` for exactly one cycle, go to WAIT.
  - WAIT: count `RES_LAT`, then latch `alu_res` and `alu_overflow` into internal registers, go to TX_LO.
  - TX_LO → TX_HI → TX_ST: sends res[7:0], then res[15:8], then {7'b0, ovf}. After TX_ST, go to IDLE.
- Transmit rule, applied in each TX state:
  - When `tx_busy` is low and the guard flag is clear: drive `tx_data`, pulse `tx_start` for one cycle, set the guard.
  - The guard blocks sampling `tx_busy` for the following cycle, covering the uart's busy-rise delay. Then clear the guard and advance.
- `alu_a`/`alu_b`/`alu_op` update when byte0 is accepted. `alu_y` updates when byte1 is accepted. All four hold until the next accepted byte0/byte1.
- `rx_ready` in EXEC/WAIT/TX states: the byte is discarded and `dropped` is set. In IDLE/HDR no byte is ever lost.
- `rx_ready` in the same cycle as the timeout expiring: the byte is accepted as byte1; the accept wins.

## Timing
- Reset values: `tx_data`=0, `tx_start`=0, `alu_a`=0, `alu_b`=0, `alu_y`=0, `alu_op`=0, `alu_exec`=0, `busy`=0, `dropped`=0, state=IDLE, guard=0.
- Reset asserted mid-command or mid-transmit: everything returns to reset values immediately. An in-flight UART byte is not cancelled.
- Byte1 accepted at cycle N:
  - `alu_y` is valid at N+1.
  - `alu_exec` is high during N+1 only.
  - The result is captured at the end of cycle N+1+`RES_LAT`.
  - The first `tx_start` is at the earliest cycle N+2+`RES_LAT`, if `tx_busy` is low.
- Consecutive `tx_start` pulses are separated by at least 2 cycles plus the `tx_busy` high time.
- Timeout: HDR is abandoned on the cycle the counter equals `TIMEOUT`. No response is sent and `dropped` is unchanged.

## Configuration
- `ALU_SEQ_ECHO_EN` defined:
  - Adds state TX_EC before TX_LO, which transmits latched byte0 first. The response is 4 bytes: byte0, res lo, res hi, status.
- `ALU_SEQ_ECHO_EN` not defined:
  - TX_EC does not exist. The response is exactly 3 bytes. All other behaviour is identical.

## Test plan
- Reset release, idle 100 cycles -> all outputs 0, `busy`=0, no `tx_start`.
- Send byte0=8'b10_011_101, then byte1=8'h06; model returns `alu_res`=16'hBEEF, ovf=1 -> `alu_op`=2, `alu_a`=3, `alu_b`=5, `alu_y`=6; one `alu_exec` pulse; TX bytes 8'hEF, 8'hBE, 8'h01 (preceded by 8'h9D when echo is enabled).
- Send byte0 only, `TIMEOUT`=100 -> back to IDLE at cycle 100 after accept, no TX. A following full command is processed normally.
- During TX_HI, hold `tx_busy` high for 500 cycles and inject an `rx_ready` -> no `tx_start` while busy, `dropped`=1, response bytes are still correct and in order.
- With `RES_LAT`=4, change `alu_res` every cycle -> the captured value is the one present 4 cycles after `alu_exec`.
- Assert `RST_N` low during WAIT -> outputs reset asynchronously, no TX follows. The next command works.

Source files
------------

// File: rtl/alu_cmd_seq_if.sv
// alu_cmd_seq_if
//   Bundles the UART byte handshake and the ALU control/result signals seen
//   by alu_cmd_seq.
//   master : the sequencer (consumes rx bytes, drives tx and ALU control)
//   slave  : the UART/ALU side (supplies rx bytes, tx_busy and ALU result)
//   UART : rx_data[7:0], rx_ready, tx_data[7:0], tx_start, tx_busy
//   ALU  : alu_a/alu_b/alu_y[2:0], alu_op[1:0], alu_exec,
//          alu_res[15:0], alu_overflow
interface alu_cmd_seq_if;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [2:0]  alu_a;
    logic [2:0]  alu_b;
    logic [2:0]  alu_y;
    logic [1:0]  alu_op;
    logic        alu_exec;
    logic [15:0] alu_res;
    logic        alu_overflow;

    modport master (
        input  rx_data, rx_ready, tx_busy, alu_res, alu_overflow,
        output tx_data, tx_start, alu_a, alu_b, alu_y, alu_op, alu_exec
    );

    modport slave (
        output rx_data, rx_ready, tx_busy, alu_res, alu_overflow,
        input  tx_data, tx_start, alu_a, alu_b, alu_y, alu_op, alu_exec
    );
endinterface

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq
//   UART-to-ALU command sequencer. Accepts a 2-byte command
//   (byte0 = {op, a, b}, byte1 = {5'bx, y}), fires one ALU execute, waits
//   RES_LAT cycles, then returns res[7:0], res[15:8], {7'b0, ovf} over the
//   UART transmitter.
//   Optional macro ALU_SEQ_ECHO_EN: byte0 is echoed before the result bytes.
// Ports:
//   CLK      system clock
//   RST_N    asynchronous active-low reset
//   bus      alu_cmd_seq_if.master (UART rx/tx handshake, ALU control/result)
//   busy     high whenever the sequencer is not idle
//   dropped  sticky; a byte arrived while executing or transmitting
module alu_cmd_seq #(
    parameter int unsigned RES_LAT = 2,
    parameter int unsigned TIMEOUT = 1_000_000,
    parameter int unsigned TO_W    = 24
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    alu_cmd_seq_if.master        bus,
    output logic                 busy,
    output logic                 dropped
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_EXEC,
        ST_WAIT,
`ifdef ALU_SEQ_ECHO_EN
        ST_TX_EC,
`endif
        ST_TX_LO,
        ST_TX_HI,
        ST_TX_ST
    } state_t;

`ifdef ALU_SEQ_ECHO_EN
    localparam state_t TX_FIRST = ST_TX_EC;
`else
    localparam state_t TX_FIRST = ST_TX_LO;
`endif

    localparam logic [3:0]      LAT_LAST = 4'(RES_LAT - 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [2:0]        a_q, a_d;
    logic [2:0]        b_q, b_d;
    logic [2:0]        y_q, y_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [3:0]        lat_q, lat_d;
    logic [15:0]       res_q, res_d;
    logic              ovf_q, ovf_d;
    logic              guard_q, guard_d;
    logic              dropped_q, dropped_d;

    logic              tx_active;
    logic [7:0]        tx_byte;
    state_t            tx_next;
    logic              tx_start_c;
    logic [7:0]        tx_data_c;
    logic              alu_exec_c;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        y_d        = y_q;
        to_cnt_d   = to_cnt_q;
        lat_d      = lat_q;
        res_d      = res_q;
        ovf_d      = ovf_q;
        guard_d    = guard_q;
        dropped_d  = dropped_q;
        tx_active  = 1'b0;
        tx_byte    = '0;
        tx_next    = ST_IDLE;
        tx_start_c = 1'b0;
        tx_data_c  = '0;
        alu_exec_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_ready) begin
                    op_d     = bus.rx_data[7:6];
                    a_d      = bus.rx_data[5:3];
                    b_d      = bus.rx_data[2:0];
                    to_cnt_d = '0;
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: begin
                // A byte arriving on the expiry cycle is still taken as byte1.
                if (bus.rx_ready) begin
                    y_d     = bus.rx_data[2:0];
                    state_d = ST_EXEC;
                end else if (to_cnt_q == TO_LIMIT) begin
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_EXEC: begin
                alu_exec_c = 1'b1;
                lat_d      = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    res_d   = bus.alu_res;
                    ovf_d   = bus.alu_overflow;
                    state_d = TX_FIRST;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
`ifdef ALU_SEQ_ECHO_EN
            ST_TX_EC: begin
                tx_active = 1'b1;
                tx_byte   = {op_q, a_q, b_q};
                tx_next   = ST_TX_LO;
            end
`endif
            ST_TX_LO: begin
                tx_active = 1'b1;
                tx_byte   = res_q[7:0];
                tx_next   = ST_TX_HI;
            end
            ST_TX_HI: begin
                tx_active = 1'b1;
                tx_byte   = res_q[15:8];
                tx_next   = ST_TX_ST;
            end
            ST_TX_ST: begin
                tx_active = 1'b1;
                tx_byte   = {7'b0, ovf_q};
                tx_next   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Shared transmit handshake: after a start, the guard cycle ignores
        // tx_busy (the UART raises it one cycle late), then the state advances.
        if (tx_active) begin
            tx_data_c = tx_byte;
            if (guard_q) begin
                guard_d = 1'b0;
                state_d = tx_next;
            end else if (!bus.tx_busy) begin
                tx_start_c = 1'b1;
                guard_d    = 1'b1;
            end
        end

        if (bus.rx_ready && state_q != ST_IDLE && state_q != ST_HDR) begin
            dropped_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            y_q       <= '0;
            to_cnt_q  <= '0;
            lat_q     <= '0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            guard_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            y_q       <= y_d;
            to_cnt_q  <= to_cnt_d;
            lat_q     <= lat_d;
            res_q     <= res_d;
            ovf_q     <= ovf_d;
            guard_q   <= guard_d;
            dropped_q <= dropped_d;
        end
    end

    assign bus.tx_data  = tx_data_c;
    assign bus.tx_start = tx_start_c;
    assign bus.alu_exec = alu_exec_c;
    assign bus.alu_a    = a_q;
    assign bus.alu_b    = b_q;
    assign bus.alu_y    = y_q;
    assign bus.alu_op   = op_q;
    assign busy         = (state_q != ST_IDLE);
    assign dropped      = dropped_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb_alu_cmd_seq
//   Self-checking bench for alu_cmd_seq (RES_LAT=4, TIMEOUT=100).
//   A UART stub raises tx_busy after each tx_start; an ALU stub drives a new
//   random result each cycle and keeps its history so the expected response
//   is the value present RES_LAT cycles after the execute strobe.
module tb_alu_cmd_seq;

    localparam int RES_LAT = 4;
    localparam int TIMEOUT = 100;
`ifdef ALU_SEQ_ECHO_EN
    localparam int NB     = 4;
    localparam int LO_IDX = 1;
`else
    localparam int NB     = 3;
    localparam int LO_IDX = 0;
`endif

    logic CLK;
    logic RST_N;
    logic busy;
    logic dropped;

    alu_cmd_seq_if bus ();

    alu_cmd_seq #(
        .RES_LAT (RES_LAT),
        .TIMEOUT (TIMEOUT),
        .TO_W    (24)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .bus     (bus),
        .busy    (busy),
        .dropped (dropped)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          busy_until = -1;
    int          last_tx = -100;
    bit          alu_rand = 0;
    bit          hold_arm = 0;
    bit          hold_used = 0;
    int          tx_base = 0;
    int          exec_base = 0;
    int          cmd_n = 0;
    logic [7:0]  cmd_b0 = '0;
    logic [7:0]  tx_q [$];
    int          tx_cyc_q [$];
    int          exec_q [$];
    logic [16:0] hist [int];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // UART busy model and ALU result source, updated just after each edge.
    initial begin
        bus.tx_busy      = 1'b0;
        bus.alu_res      = '0;
        bus.alu_overflow = 1'b0;
        forever begin
            @(posedge CLK);
            cyc = cyc + 1;
            #1;
            bus.tx_busy = (cyc <= busy_until);
            if (alu_rand) begin
                bus.alu_res      = 16'($urandom);
                bus.alu_overflow = 1'($urandom);
            end else begin
                bus.alu_res      = 16'hBEEF;
                bus.alu_overflow = 1'b1;
            end
            hist[cyc] = {bus.alu_overflow, bus.alu_res};
        end
    end

    // Output monitor: collects transmitted bytes and execute strobes.
    always @(negedge CLK) begin
        if (RST_N && bus.tx_start) begin
            check("tx_while_busy", {31'b0, bus.tx_busy}, 32'd0);
            check("tx_spacing", {31'b0, (cyc - last_tx) >= 2}, 32'd1);
            last_tx = cyc;
            tx_q.push_back(bus.tx_data);
            tx_cyc_q.push_back(cyc);
            if (hold_arm && !hold_used && (tx_q.size() - tx_base == LO_IDX + 1)) begin
                hold_used  = 1'b1;
                busy_until = cyc + 500;
            end else begin
                busy_until = cyc + $urandom_range(1, 6);
            end
        end
        if (bus.alu_exec) exec_q.push_back(cyc);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while ((busy || bus.tx_busy) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("idle_wait", {30'b0, busy, bus.tx_busy}, 32'd0);
    endtask

    task automatic start_cmd(input logic [7:0] b0, input logic [7:0] b1, input int gap);
        wait_idle();
        tx_base   = tx_q.size();
        exec_base = exec_q.size();
        step();
        bus.rx_ready = 1'b1;
        bus.rx_data  = b0;
        step();
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'($urandom);
        repeat (gap) step();
        bus.rx_ready = 1'b1;
        bus.rx_data  = b1;
        cmd_n  = cyc;
        cmd_b0 = b0;
        step();
        bus.rx_ready = 1'b0;
        @(negedge CLK);
        check("alu_op", {30'b0, bus.alu_op}, {30'b0, b0[7:6]});
        check("alu_a", {29'b0, bus.alu_a}, {29'b0, b0[5:3]});
        check("alu_b", {29'b0, bus.alu_b}, {29'b0, b0[2:0]});
        check("alu_y", {29'b0, bus.alu_y}, {29'b0, b1[2:0]});
        check("alu_exec", {31'b0, bus.alu_exec}, 32'd1);
    endtask

    task automatic finish_cmd();
        int          n = 0;
        logic [16:0] r;
        logic [7:0]  e [$];
        while (((tx_q.size() - tx_base) < NB || busy) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check("resp_done", {31'b0, n < 3000}, 32'd1);
        if (hist.exists(cmd_n + 1 + RES_LAT)) r = hist[cmd_n + 1 + RES_LAT];
        else r = 'x;
        if (NB == 4) e.push_back(cmd_b0);
        e.push_back(r[7:0]);
        e.push_back(r[15:8]);
        e.push_back({7'b0, r[16]});
        check("tx_count", tx_q.size() - tx_base, NB);
        for (int i = 0; i < NB; i++) begin
            check("tx_byte", {24'b0, tx_q[tx_base + i]}, {24'b0, e[i]});
        end
        check("exec_count", exec_q.size() - exec_base, 1);
        check("exec_cyc", exec_q[exec_base], cmd_n + 1);
        check("first_tx_cyc", tx_cyc_q[tx_base], cmd_n + 2 + RES_LAT);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb0;
        RST_N        = 1'b0;
        bus.rx_ready = 1'b0;
        bus.rx_data  = '0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        // Idle after reset
        repeat (100) @(negedge CLK);
        check("rst_tx_data", {24'b0, bus.tx_data}, 32'd0);
        check("rst_tx_start", {31'b0, bus.tx_start}, 32'd0);
        check("rst_abyop", {21'b0, bus.alu_a, bus.alu_b, bus.alu_y, bus.alu_op}, 32'd0);
        check("rst_exec", {31'b0, bus.alu_exec}, 32'd0);
        check("rst_busy_dropped", {30'b0, busy, dropped}, 32'd0);
        check("rst_no_tx", tx_q.size(), 0);

        // Directed command: result 16'hBEEF with overflow
        start_cmd(8'b10_011_101, 8'h06, 3);
        finish_cmd();
        check("dir_lo", {24'b0, tx_q[tx_base + LO_IDX]}, 32'hEF);
        check("dir_hi", {24'b0, tx_q[tx_base + LO_IDX + 1]}, 32'hBE);
        check("dir_st", {24'b0, tx_q[tx_base + LO_IDX + 2]}, 32'h01);
        check("dir_op", {30'b0, bus.alu_op}, 32'd2);

        // Random commands against a result that changes every cycle
        alu_rand = 1'b1;
        for (int i = 0; i < 12; i++) begin
            start_cmd(8'($urandom), 8'($urandom), $urandom_range(0, 20));
            finish_cmd();
        end
        check("no_drop_yet", {31'b0, dropped}, 32'd0);

        // Timeout: byte0 only
        wait_idle();
        tx_base   = tx_q.size();
        exec_base = exec_q.size();
        rb0 = 8'($urandom);
        step();
        bus.rx_ready = 1'b1;
        bus.rx_data  = rb0;
        step();
        bus.rx_ready = 1'b0;
        repeat (TIMEOUT) step();
        @(negedge CLK);
        check("to_still_hdr", {31'b0, busy}, 32'd1);
        step();
        @(negedge CLK);
        check("to_idle", {31'b0, busy}, 32'd0);
        check("to_a_latched", {29'b0, bus.alu_a}, {29'b0, rb0[5:3]});
        check("to_dropped", {31'b0, dropped}, 32'd0);
        repeat (20) @(negedge CLK);
        check("to_no_tx", tx_q.size() - tx_base, 0);
        check("to_no_exec", exec_q.size() - exec_base, 0);
        start_cmd(8'($urandom), 8'($urandom), 5);
        finish_cmd();

        // byte1 on the expiry cycle is accepted
        start_cmd(8'($urandom), 8'($urandom), TIMEOUT);
        finish_cmd();

        // tx_busy held long during TX_HI, with a byte injected meanwhile
        hold_arm = 1'b1;
        start_cmd(8'($urandom), 8'($urandom), 2);
        begin
            int n = 0;
            while ((tx_q.size() - tx_base) < LO_IDX + 1 && n < 200) begin
                @(negedge CLK);
                n++;
            end
        end
        repeat (20) @(negedge CLK);
        check("hold_busy", {30'b0, busy, bus.tx_busy}, 32'd3);
        check("hold_no_tx", tx_q.size() - tx_base, LO_IDX + 1);
        check("hold_drop_pre", {31'b0, dropped}, 32'd0);
        step();
        bus.rx_ready = 1'b1;
        bus.rx_data  = 8'($urandom);
        step();
        bus.rx_ready = 1'b0;
        @(negedge CLK);
        check("hold_drop_set", {31'b0, dropped}, 32'd1);
        finish_cmd();
        check("hold_drop_sticky", {31'b0, dropped}, 32'd1);

        // Asynchronous reset during WAIT
        start_cmd(8'($urandom) | 8'h3F, 8'h07, 1);
        step();
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_abyop", {21'b0, bus.alu_a, bus.alu_b, bus.alu_y, bus.alu_op}, 32'd0);
        check("arst_tx", {23'b0, bus.tx_start, bus.tx_data}, 32'd0);
        check("arst_exec_drop", {30'b0, bus.alu_exec, dropped}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (60) @(negedge CLK);
        check("arst_no_tx", tx_q.size() - tx_base, 0);
        check("arst_one_exec", exec_q.size() - exec_base, 1);
        start_cmd(8'($urandom), 8'($urandom), 0);
        finish_cmd();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
